// File: rtl/lifo_pkg.sv
// Shared helpers for the stack/queue family.
package lifo_pkg;
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction
endpackage

// File: rtl/lifo_sync_if.sv
// Request/response bundle between a producer/consumer and lifo_sync.
interface lifo_sync_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 12
);
    import lifo_pkg::*;
    localparam int CNT_W = cnt_width(DEPTH);

    logic             clear;
    logic             push;
    logic [WIDTH-1:0] pushData;
    logic             pop;
    logic [WIDTH-1:0] popData;
    logic             popValid;
    logic [WIDTH-1:0] topData;
    logic [CNT_W-1:0] count;
    logic             empty;
    logic             full;
    logic             almostFull;
    logic             overflow;
    logic             underflow;
    logic             errClear;

    modport master (
        output clear, push, pushData, pop, errClear,
        input  popData, popValid, topData, count,
        input  empty, full, almostFull, overflow, underflow
    );

    modport slave (
        input  clear, push, pushData, pop, errClear,
        output popData, popValid, topData, count,
        output empty, full, almostFull, overflow, underflow
    );
endinterface

// File: rtl/lifo_mem.sv
// Unreset DEPTH x WIDTH register file: one write port, one async read port.
module lifo_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 12,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/lifo_sync.sv
// Synchronous LIFO with registered pop port, replace-top/bypass,
// flush, occupancy and sticky error flags.
module lifo_sync #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 12,
    parameter int AFULL_LVL = DEPTH - 2
) (
    input logic       clk,
    input logic       rst_n,
    lifo_sync_if.slave bus
);
    import lifo_pkg::*;
    localparam int CNT_W = cnt_width(DEPTH);
    localparam int AW    = $clog2(DEPTH);

    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] pop_data;
    logic             pop_valid;
    logic             ovf;
    logic             udf;

    logic             has;
    logic             is_full;
    logic             do_swap;
    logic             do_push;
    logic             do_pop;
    logic             we;
    logic [AW-1:0]    top_idx;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] rd;

    assign has     = cnt != '0;
    assign is_full = cnt == CNT_W'(DEPTH);
    assign do_swap = !bus.clear && bus.push && bus.pop;
    assign do_push = !bus.clear && bus.push && !bus.pop;
    assign do_pop  = !bus.clear && !bus.push && bus.pop;

    // Swap overwrites the current top; a plain push writes one above it.
    assign top_idx = has ? AW'(cnt - 1'b1) : '0;
    assign wr_addr = bus.pop ? top_idx : AW'(cnt);
    assign we      = (do_swap && has) || (do_push && !is_full);

    lifo_mem #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .AW   (AW)
    ) u_mem (
        .clk  (clk),
        .we   (we),
        .waddr(wr_addr),
        .wdata(bus.pushData),
        .raddr(top_idx),
        .rdata(rd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            pop_data  <= '0;
            pop_valid <= 1'b0;
        end else begin
            unique case (1'b1)
                bus.clear: begin
                    cnt       <= '0;
                    pop_valid <= 1'b0;
                end
                do_swap: begin
                    pop_data  <= has ? rd : bus.pushData;
                    pop_valid <= 1'b1;
                end
                do_push: begin
                    pop_valid <= 1'b0;
                    if (!is_full) cnt <= cnt + 1'b1;
                end
                do_pop: begin
                    pop_valid <= has;
                    if (has) begin
                        pop_data <= rd;
                        cnt      <= cnt - 1'b1;
                    end
                end
                default: pop_valid <= 1'b0;
            endcase
        end
    end

    // A new error in the same cycle as errClear keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
            udf <= 1'b0;
        end else begin
            ovf <= (ovf && !bus.errClear) || (do_push && is_full);
            udf <= (udf && !bus.errClear) || (do_pop && !has);
        end
    end

    assign bus.popData    = pop_data;
    assign bus.popValid   = pop_valid;
    assign bus.topData    = has ? rd : '0;
    assign bus.count      = cnt;
    assign bus.empty      = !has;
    assign bus.full       = is_full;
    assign bus.almostFull = cnt >= CNT_W'(AFULL_LVL);
    assign bus.overflow   = ovf;
    assign bus.underflow  = udf;
endmodule
